// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with an internal baud divider.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       UART_TX,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int              DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Divider free-runs in every non-idle state and restarts on each state entry.
    if (state_q != S_IDLE) begin
      div_d = bit_end ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d = S_START;
          div_d   = '0;
          bit_d   = 3'd0;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase

    // Line and status are registered from the next state so UART_TX never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign UART_TX = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter using a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       UART_TX, tx_busy, tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  uart_transmitter #(.CLKS_PER_BIT(N)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .UART_TX (UART_TX),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc++;

  // Expected line level for frame bit b: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b want 100", i, {UART_TX, tx_busy, tx_done});
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got %b want 100", i, {UART_TX, tx_busy, tx_done});
      end
    end
  endtask

  task automatic test_single(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
    for (int i = 0; i < FB*N; i++) begin
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== {exp_bit(d, i/N), 2'b10}) begin
        n_fail++;
        $display("FAIL single_%h cyc%0d: got %b want %b", d, i,
                 {UART_TX, tx_busy, tx_done}, {exp_bit(d, i/N), 2'b10});
      end
      @(negedge sysclk);
    end
    n_tests++;
    if ({UART_TX, tx_busy, tx_done} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_%h done: got %b want 101", d, {UART_TX, tx_busy, tx_done});
    end
    @(negedge sysclk);
    n_tests++;
    if ({UART_TX, tx_busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_%h after_done: got %b want 100", d, {UART_TX, tx_busy, tx_done});
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d = 8'hA3;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
    for (int i = 0; i < FB*N; i++) begin
      if (i == 9)  begin tx_start = 1'b1; tx_data = 8'hFF; end
      if (i == 10) tx_start = 1'b0;
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== {exp_bit(d, i/N), 2'b10}) begin
        n_fail++;
        $display("FAIL busy_ignore cyc%0d: got %b want %b", i,
                 {UART_TX, tx_busy, tx_done}, {exp_bit(d, i/N), 2'b10});
      end
      @(negedge sysclk);
    end
    n_tests++;
    if ({UART_TX, tx_busy, tx_done} !== 3'b101) begin
      n_fail++;
      $display("FAIL busy_ignore done: got %b want 101", {UART_TX, tx_busy, tx_done});
    end
    for (int i = 0; i < 3*N; i++) begin
      @(negedge sysclk);
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL busy_ignore no_second cyc%0d: got %b want 100", i, {UART_TX, tx_busy, tx_done});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [2] = '{8'h00, 8'h81};
    int done_cyc [2];
    tx_data  = d[0];
    tx_start = 1'b1;
    @(negedge sysclk);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) tx_start = 1'b0;
      for (int i = 0; i < FB*N; i++) begin
        n_tests++;
        if ({UART_TX, tx_busy, tx_done} !== {exp_bit(d[f], i/N), 2'b10}) begin
          n_fail++;
          $display("FAIL b2b_f%0d cyc%0d: got %b want %b", f, i,
                   {UART_TX, tx_busy, tx_done}, {exp_bit(d[f], i/N), 2'b10});
        end
        @(negedge sysclk);
      end
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== 3'b101) begin
        n_fail++;
        $display("FAIL b2b_f%0d done: got %b want 101", f, {UART_TX, tx_busy, tx_done});
      end
      done_cyc[f] = cyc;
      if (f == 0) tx_data = d[1];
      @(negedge sysclk);
    end
    n_tests++;
    if (done_cyc[1] - done_cyc[0] !== FB*N + 1) begin
      n_fail++;
      $display("FAIL b2b_done_spacing: got %0d want %0d", done_cyc[1] - done_cyc[0], FB*N + 1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge sysclk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge sysclk);
      for (int i = 0; i < FB*N; i++) begin
        tx_data  = 8'($urandom);
        tx_start = 1'($urandom_range(0, 1));
        n_tests++;
        if ({UART_TX, tx_busy, tx_done} !== {exp_bit(d, i/N), 2'b10}) begin
          n_fail++;
          $display("FAIL random_%h cyc%0d: got %b want %b", d, i,
                   {UART_TX, tx_busy, tx_done}, {exp_bit(d, i/N), 2'b10});
        end
        @(negedge sysclk);
      end
      tx_start = 1'b0;
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== 3'b101) begin
        n_fail++;
        $display("FAIL random_%h done: got %b want 101", d, {UART_TX, tx_busy, tx_done});
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d = 8'($urandom);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
    for (int i = 0; i < 4*N + 1; i++) begin
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== {exp_bit(d, i/N), 2'b10}) begin
        n_fail++;
        $display("FAIL mid_reset pre cyc%0d: got %b want %b", i,
                 {UART_TX, tx_busy, tx_done}, {exp_bit(d, i/N), 2'b10});
      end
      @(negedge sysclk);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({UART_TX, tx_busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_reset async: got %b want 100", {UART_TX, tx_busy, tx_done});
    end
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    for (int i = 0; i < (FB+1)*N; i++) begin
      @(negedge sysclk);
      n_tests++;
      if ({UART_TX, tx_busy, tx_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL mid_reset quiet cyc%0d: got %b want 100", i, {UART_TX, tx_busy, tx_done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_single(8'h07);
    test_single(8'h03);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
